// File: rtl/ex_branch_ctrl.sv
// EX-stage branch resolution: flag register, condition evaluation, fetch redirect,
// post-redirect squash window, halt latch and a saturating taken-branch counter.
module ex_branch_ctrl #(
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             stall,
  input  logic             set_flags,
  input  logic             V,
  input  logic             Z,
  input  logic             N,
  input  logic             is_branch,
  input  logic [2:0]       cond,
  input  logic             is_halt,
  input  logic [15:0]      target,
  output logic             pc_sel,
  output logic [15:0]      pc_target,
  output logic             flush,
  output logic             ex_kill,
  output logic [2:0]       flags,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int SQ_W = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SQ_W-1:0]   r_sq_cnt;
  logic [SQ_W-1:0]   w_sq_cnt_nxt;
  logic              r_pc_sel;
  logic              r_flush;
  logic              r_ex_kill;
  logic              r_halted;
  logic [15:0]       r_pc_target;
  logic [2:0]        r_flags;
  logic [CNT_W-1:0]  r_taken_cnt;

  logic              w_accept;
  logic              w_cond_true;
  logic              w_halt_req;
  logic              w_redirect;

  assign w_accept   = (r_state == ST_RUN) && ex_valid && !stall;
  assign w_halt_req = w_accept && is_halt;
  // Halt takes precedence over a coincident taken branch.
  assign w_redirect = w_accept && is_branch && w_cond_true && !is_halt;

  // Branch condition evaluated against the registered {V,Z,N}.
  always_comb begin
    w_cond_true = 1'b0;
    case (cond)
      3'b000:  w_cond_true = !r_flags[1];
      3'b001:  w_cond_true = r_flags[1];
      3'b010:  w_cond_true = !r_flags[1] && !r_flags[0];
      3'b011:  w_cond_true = r_flags[0];
      3'b100:  w_cond_true = r_flags[1] || !r_flags[0];
      3'b101:  w_cond_true = r_flags[0] || r_flags[1];
      3'b110:  w_cond_true = r_flags[2];
      3'b111:  w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  // Next-state logic; the squash counter runs down regardless of stall.
  always_comb begin
    w_state_nxt  = r_state;
    w_sq_cnt_nxt = r_sq_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_halt_req) begin
          w_state_nxt = ST_HALT;
        end else if (w_redirect) begin
          w_state_nxt  = ST_SQUASH;
          w_sq_cnt_nxt = SQ_W'(SQUASH_CYCLES - 1);
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_SQUASH: begin
        if (r_sq_cnt == {SQ_W{1'b0}}) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_sq_cnt_nxt = r_sq_cnt - SQ_W'(1);
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt  = ST_RUN;
        w_sq_cnt_nxt = {SQ_W{1'b0}};
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_RUN;
      r_sq_cnt <= {SQ_W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_sq_cnt <= w_sq_cnt_nxt;
    end
  end

  // Registered outputs; kill/halted are decoded from the next state so they
  // line up with the cycle the FSM is actually in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_sel    <= 1'b0;
      r_flush     <= 1'b0;
      r_pc_target <= 16'h0000;
      r_ex_kill   <= 1'b0;
      r_halted    <= 1'b0;
      r_flags     <= 3'b000;
      r_taken_cnt <= {CNT_W{1'b0}};
    end else begin
      r_pc_sel  <= w_redirect;
      r_flush   <= w_redirect;
      r_ex_kill <= (w_state_nxt != ST_RUN);
      r_halted  <= (w_state_nxt == ST_HALT);
      if (w_redirect) begin
        r_pc_target <= target;
      end
      if (w_accept && set_flags) begin
        r_flags <= {V, Z, N};
      end
      if (w_redirect && (r_taken_cnt != {CNT_W{1'b1}})) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_sel    = r_pc_sel;
  assign flush     = r_flush;
  assign pc_target = r_pc_target;
  assign ex_kill   = r_ex_kill;
  assign halted    = r_halted;
  assign flags     = r_flags;
  assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_ex_branch_ctrl.sv
// Directed bench for ex_branch_ctrl; built with a 4-bit counter so saturation is reachable.
module tb_ex_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, stall, set_flags, V, Z, N, is_branch, is_halt;
  logic [2:0]  cond;
  logic [15:0] target;
  logic        pc_sel, flush, ex_kill, halted;
  logic [15:0] pc_target;
  logic [2:0]  flags;
  logic [3:0]  taken_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_branch_ctrl #(.SQUASH_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall), .set_flags(set_flags),
    .V(V), .Z(Z), .N(N), .is_branch(is_branch), .cond(cond), .is_halt(is_halt),
    .target(target), .pc_sel(pc_sel), .pc_target(pc_target), .flush(flush),
    .ex_kill(ex_kill), .flags(flags), .halted(halted), .taken_cnt(taken_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; stall = 1'b0; set_flags = 1'b0; V = 1'b0; Z = 1'b0; N = 1'b0;
    is_branch = 1'b0; cond = 3'b000; is_halt = 1'b0; target = 16'h0000;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (pc_sel !== 1'b0) begin n_fail++; $display("FAIL reset_pc_sel got %b exp 0", pc_sel); end
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", flush); end
    n_tests++; if (pc_target !== 16'h0000) begin n_fail++; $display("FAIL reset_pc_target got %h exp 0000", pc_target); end
    n_tests++; if (ex_kill !== 1'b0) begin n_fail++; $display("FAIL reset_ex_kill got %b exp 0", ex_kill); end
    n_tests++; if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", flags); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted); end
    n_tests++; if (taken_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_taken_cnt got %h exp 0", taken_cnt); end
  endtask

  task automatic test_beq_taken();
    do_reset();
    ex_valid = 1'b1; set_flags = 1'b1; Z = 1'b1;
    step();
    n_tests++; if (flags !== 3'b010) begin n_fail++; $display("FAIL beq_flags got %b exp 010", flags); end
    set_flags = 1'b0; Z = 1'b0; is_branch = 1'b1; cond = 3'b001; target = 16'h0040;
    step();
    n_tests++; if (pc_sel !== 1'b1) begin n_fail++; $display("FAIL beq_pc_sel got %b exp 1", pc_sel); end
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL beq_flush got %b exp 1", flush); end
    n_tests++; if (pc_target !== 16'h0040) begin n_fail++; $display("FAIL beq_target got %h exp 0040", pc_target); end
    n_tests++; if (ex_kill !== 1'b1) begin n_fail++; $display("FAIL beq_kill_t2 got %b exp 1", ex_kill); end
    n_tests++; if (taken_cnt !== 4'h1) begin n_fail++; $display("FAIL beq_cnt got %h exp 1", taken_cnt); end
    idle();
    step();
    n_tests++; if (pc_sel !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL beq_pulse_len got %b%b exp 00", pc_sel, flush); end
    n_tests++; if (ex_kill !== 1'b1) begin n_fail++; $display("FAIL beq_kill_t3 got %b exp 1", ex_kill); end
    n_tests++; if (pc_target !== 16'h0040) begin n_fail++; $display("FAIL beq_target_hold got %h exp 0040", pc_target); end
    step();
    n_tests++; if (ex_kill !== 1'b0) begin n_fail++; $display("FAIL beq_kill_t4 got %b exp 0", ex_kill); end
  endtask

  task automatic test_not_taken();
    do_reset();
    ex_valid = 1'b1; is_branch = 1'b1; cond = 3'b001; target = 16'h1234;
    step();
    idle();
    n_tests++; if (pc_sel !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL nt_redirect got %b%b exp 00", pc_sel, flush); end
    n_tests++; if (ex_kill !== 1'b0) begin n_fail++; $display("FAIL nt_kill got %b exp 0", ex_kill); end
    n_tests++; if (taken_cnt !== 4'h0) begin n_fail++; $display("FAIL nt_cnt got %h exp 0", taken_cnt); end
    n_tests++; if (pc_target !== 16'h0000) begin n_fail++; $display("FAIL nt_target got %h exp 0000", pc_target); end
  endtask

  task automatic test_conditions();
    // {V,Z,N}, cond, expected taken
    logic [2:0] f_tab [14] = '{3'b000, 3'b010, 3'b010, 3'b000, 3'b001, 3'b001, 3'b000,
                               3'b011, 3'b001, 3'b000, 3'b001, 3'b100, 3'b000, 3'b000};
    logic [2:0] c_tab [14] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4,
                               3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7};
    logic       e_tab [14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                               1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      do_reset();
      ex_valid = 1'b1; set_flags = 1'b1;
      {V, Z, N} = f_tab[i];
      step();
      set_flags = 1'b0; V = 1'b0; Z = 1'b0; N = 1'b0;
      is_branch = 1'b1; cond = c_tab[i]; target = 16'h0100 + 16'(i);
      step();
      idle();
      n_tests++;
      if (pc_sel !== e_tab[i]) begin
        n_fail++;
        $display("FAIL cond_%0d flags=%b cond=%b got pc_sel %b exp %b", i, f_tab[i], c_tab[i], pc_sel, e_tab[i]);
      end
      step();
      step();
    end
  endtask

  task automatic test_stall();
    int flushes;
    do_reset();
    ex_valid = 1'b1; is_branch = 1'b1; cond = 3'b111; target = 16'hBEEF; stall = 1'b1;
    flushes = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (flush === 1'b1) flushes++;
      n_tests++; if (pc_sel !== 1'b0) begin n_fail++; $display("FAIL stall_pc_sel_%0d got %b exp 0", i, pc_sel); end
    end
    stall = 1'b0;
    step();
    idle();
    n_tests++; if (pc_sel !== 1'b1 || pc_target !== 16'hBEEF) begin n_fail++; $display("FAIL stall_redirect got %b %h exp 1 beef", pc_sel, pc_target); end
    if (flush === 1'b1) flushes++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (flush === 1'b1) flushes++;
    end
    n_tests++; if (flushes != 1) begin n_fail++; $display("FAIL stall_flush_pulses got %0d exp 1", flushes); end
    n_tests++; if (taken_cnt !== 4'h1) begin n_fail++; $display("FAIL stall_cnt got %h exp 1", taken_cnt); end
  endtask

  task automatic test_squash_ignore();
    do_reset();
    ex_valid = 1'b1; is_branch = 1'b1; cond = 3'b111; target = 16'h0200;
    step();
    n_tests++; if (pc_sel !== 1'b1) begin n_fail++; $display("FAIL sq_first_redirect got %b exp 1", pc_sel); end
    set_flags = 1'b1; V = 1'b1; target = 16'h0300; is_halt = 1'b0;
    step();
    n_tests++; if (pc_sel !== 1'b0) begin n_fail++; $display("FAIL sq_second_redirect got %b exp 0", pc_sel); end
    n_tests++; if (flags !== 3'b000) begin n_fail++; $display("FAIL sq_flags got %b exp 000", flags); end
    n_tests++; if (ex_kill !== 1'b1) begin n_fail++; $display("FAIL sq_kill got %b exp 1", ex_kill); end
    stall = 1'b1;
    step();
    idle();
    n_tests++; if (ex_kill !== 1'b0) begin n_fail++; $display("FAIL sq_exit_under_stall got %b exp 0", ex_kill); end
    n_tests++; if (flags !== 3'b000 || pc_target !== 16'h0200) begin n_fail++; $display("FAIL sq_state got %b %h exp 000 0200", flags, pc_target); end
    n_tests++; if (taken_cnt !== 4'h1) begin n_fail++; $display("FAIL sq_cnt got %h exp 1", taken_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    ex_valid = 1'b1; is_halt = 1'b1; is_branch = 1'b1; cond = 3'b111; target = 16'h0500;
    step();
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted got %b exp 1", halted); end
    n_tests++; if (pc_sel !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL halt_no_redirect got %b%b exp 00", pc_sel, flush); end
    n_tests++; if (ex_kill !== 1'b1) begin n_fail++; $display("FAIL halt_kill got %b exp 1", ex_kill); end
    is_halt = 1'b0; set_flags = 1'b1; V = 1'b1; Z = 1'b1; N = 1'b1;
    step();
    step();
    n_tests++; if (flags !== 3'b000 || taken_cnt !== 4'h0) begin n_fail++; $display("FAIL halt_frozen got %b %h exp 000 0", flags, taken_cnt); end
    n_tests++; if (halted !== 1'b1 || pc_sel !== 1'b0) begin n_fail++; $display("FAIL halt_sticky got %b %b exp 1 0", halted, pc_sel); end
    rst = 1'b1;
    step();
    n_tests++; if ({pc_sel, flush, ex_kill, halted} !== 4'b0000 || flags !== 3'b000 || pc_target !== 16'h0000 || taken_cnt !== 4'h0) begin
      n_fail++; $display("FAIL halt_reset got %b%b%b%b %b %h %h exp 0000 000 0000 0", pc_sel, flush, ex_kill, halted, flags, pc_target, taken_cnt);
    end
    rst = 1'b0; set_flags = 1'b0; V = 1'b0; Z = 1'b0; N = 1'b0; target = 16'h0600;
    step();
    idle();
    n_tests++; if (pc_sel !== 1'b1 || pc_target !== 16'h0600) begin n_fail++; $display("FAIL halt_after_reset got %b %h exp 1 0600", pc_sel, pc_target); end
    step();
    step();
  endtask

  task automatic test_reset_mid_squash();
    do_reset();
    ex_valid = 1'b1; is_branch = 1'b1; cond = 3'b111; target = 16'h0700;
    step();
    rst = 1'b1;
    step();
    n_tests++; if (ex_kill !== 1'b0 || pc_sel !== 1'b0 || taken_cnt !== 4'h0 || pc_target !== 16'h0000) begin
      n_fail++; $display("FAIL rst_squash got %b %b %h %h exp 0 0 0 0000", ex_kill, pc_sel, taken_cnt, pc_target);
    end
    rst = 1'b0;
    step();
    idle();
    n_tests++; if (pc_sel !== 1'b1) begin n_fail++; $display("FAIL rst_squash_run got %b exp 1", pc_sel); end
    step();
    step();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      ex_valid = 1'b1; is_branch = 1'b1; cond = 3'b111; target = 16'(i);
      step();
      idle();
      if (i == 0 || i == 14 || i == 15 || i == 16) begin
        n_tests++;
        if (taken_cnt !== ((i == 0) ? 4'h1 : 4'hF)) begin
          n_fail++; $display("FAIL sat_cnt_%0d got %h exp %h", i, taken_cnt, (i == 0) ? 4'h1 : 4'hF);
        end
      end
      step();
      step();
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    test_reset();
    test_beq_taken();
    test_not_taken();
    test_conditions();
    test_stall();
    test_squash_ignore();
    test_halt();
    test_reset_mid_squash();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
